// File: rtl/dot_product_accum_pkg.sv
`default_nettype none
// ============================================================================
// Module      : dot_product_accum_pkg
// Description : Shared widths, defaults and FSM encoding for the
//               dot-product multiply-accumulate stage.
// Revision    : 1.0 - initial release
// ============================================================================
package dot_product_accum_pkg;

    localparam int c_OP_W        = 8;   // operand width
    localparam int c_PROD_W      = 16;  // full product width
    localparam int c_VEC_LEN_DEF = 4;   // default products per dot product
    localparam int c_ACC_W_DEF   = 20;  // default accumulator width

    // Control FSM: collect elements, let the pipeline empty, present result
    typedef enum logic [1:0] {
        ST_ACCUM = 2'd0,
        ST_DRAIN = 2'd1,
        ST_HOLD  = 2'd2
    } state_t;

endpackage : dot_product_accum_pkg
`default_nettype wire

// File: rtl/dot_product_accum_if.sv
`default_nettype none
// ============================================================================
// Module      : dot_product_accum_if
// Description : Operand input stream and result output stream of the
//               dot-product stage, bundled with producer/consumer modports.
// Revision    : 1.0 - initial release
// ============================================================================
interface dot_product_accum_if
    import dot_product_accum_pkg::*;
#(
    parameter int ACC_W = c_ACC_W_DEF
) ();

    logic              in_valid;
    logic              in_ready;
    logic [c_OP_W-1:0] in_a;
    logic [c_OP_W-1:0] in_b;
    logic              out_valid;
    logic              out_ready;
    logic [ACC_W-1:0]  out_sum;
    logic              out_ovf;

    // Environment side: supplies operands, consumes results
    modport master (
        output in_valid, in_a, in_b, out_ready,
        input  in_ready, out_valid, out_sum, out_ovf
    );

    // Block side
    modport slave (
        input  in_valid, in_a, in_b, out_ready,
        output in_ready, out_valid, out_sum, out_ovf
    );

endinterface : dot_product_accum_if
`default_nettype wire

// File: rtl/parallel_unsigned_mult.sv
`default_nettype none
// ============================================================================
// Module      : parallel_unsigned_mult
// Description : Combinational 8x8 unsigned Wallace-tree multiplier. Partial
//               products are reduced with layers of 3:2 carry-save adders,
//               then resolved by a single carry-propagate add.
// Revision    : 1.0 - initial release
// ============================================================================
module parallel_unsigned_mult
    import dot_product_accum_pkg::*;
(
    input  wire logic [c_OP_W-1:0]   i_a,
    input  wire logic [c_OP_W-1:0]   i_b,
    output logic      [c_PROD_W-1:0] o_prod
);

    function automatic logic [c_PROD_W-1:0] csa_sum(
        input logic [c_PROD_W-1:0] x, y, z
    );
        return x ^ y ^ z;
    endfunction

    // Carry bits move one column left; the true product fits in 16 bits,
    // so bits shifted out of the top are always zero.
    function automatic logic [c_PROD_W-1:0] csa_carry(
        input logic [c_PROD_W-1:0] x, y, z
    );
        return ((x & y) | (x & z) | (y & z)) << 1;
    endfunction

    logic [c_PROD_W-1:0] w_pp [c_OP_W];

    generate
        for (genvar i = 0; i < c_OP_W; i++) begin : g_pp
            assign w_pp[i] = c_PROD_W'(i_a & {c_OP_W{i_b[i]}}) << i;
        end
    endgenerate

    // Layer 1: 8 rows -> 6
    logic [c_PROD_W-1:0] w_s0, w_c0, w_s1, w_c1;
    assign w_s0 = csa_sum  (w_pp[0], w_pp[1], w_pp[2]);
    assign w_c0 = csa_carry(w_pp[0], w_pp[1], w_pp[2]);
    assign w_s1 = csa_sum  (w_pp[3], w_pp[4], w_pp[5]);
    assign w_c1 = csa_carry(w_pp[3], w_pp[4], w_pp[5]);

    // Layer 2: 6 rows -> 4
    logic [c_PROD_W-1:0] w_s2, w_c2, w_s3, w_c3;
    assign w_s2 = csa_sum  (w_s0, w_c0, w_s1);
    assign w_c2 = csa_carry(w_s0, w_c0, w_s1);
    assign w_s3 = csa_sum  (w_c1, w_pp[6], w_pp[7]);
    assign w_c3 = csa_carry(w_c1, w_pp[6], w_pp[7]);

    // Layer 3: 4 rows -> 3
    logic [c_PROD_W-1:0] w_s4, w_c4;
    assign w_s4 = csa_sum  (w_s2, w_c2, w_s3);
    assign w_c4 = csa_carry(w_s2, w_c2, w_s3);

    // Layer 4: 3 rows -> 2
    logic [c_PROD_W-1:0] w_s5, w_c5;
    assign w_s5 = csa_sum  (w_s4, w_c4, w_c3);
    assign w_c5 = csa_carry(w_s4, w_c4, w_c3);

    // Final carry-propagate add
    assign o_prod = w_s5 + w_c5;

endmodule : parallel_unsigned_mult
`default_nettype wire

// File: rtl/dot_product_accum.sv
`default_nettype none
// ============================================================================
// Module      : dot_product_accum
// Description : Two-stage multiply-accumulate. Accepts VEC_LEN operand pairs,
//               accumulates their products and presents the dot product with
//               a sticky carry-out flag on a valid/ready result stream.
// Revision    : 1.0 - initial release
// ============================================================================
module dot_product_accum
    import dot_product_accum_pkg::*;
#(
    parameter int VEC_LEN = c_VEC_LEN_DEF,
    parameter int ACC_W   = c_ACC_W_DEF,
    parameter int CNT_W   = 8
) (
    input  wire logic          clk,
    input  wire logic          rst,
    dot_product_accum_if.slave bus
);

    localparam logic [CNT_W-1:0] c_LAST = CNT_W'(VEC_LEN - 1);

    state_t              r_state, w_state_nxt;
    logic [CNT_W-1:0]    r_cnt;
    logic                r_v1, r_v2;
    logic [c_OP_W-1:0]   r_a, r_b;
    logic [c_PROD_W-1:0] r_prod, w_prod;
    logic [ACC_W-1:0]    r_acc;
    logic                r_ovf;
    logic [ACC_W:0]      w_sum;
    logic                w_in_ready;
    logic                w_accept;
    logic                w_out_hs;

    assign w_accept = bus.in_valid && w_in_ready;
    assign w_out_hs = (r_state == ST_HOLD) && bus.out_ready;
    assign w_sum    = {1'b0, r_acc} + (ACC_W + 1)'(r_prod);

    parallel_unsigned_mult u_mult (
        .i_a    (r_a),
        .i_b    (r_b),
        .o_prod (w_prod)
    );

    // Stage 1: capture accepted operands; a bubble clears v1 only
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_v1 <= 1'b0;
            r_a  <= '0;
            r_b  <= '0;
        end else begin
            r_v1 <= w_accept;
            if (w_accept) begin
                r_a <= bus.in_a;
                r_b <= bus.in_b;
            end
        end
    end

    // Stage 2: register the product of valid stage-1 operands
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_v2   <= 1'b0;
            r_prod <= '0;
        end else begin
            r_v2 <= r_v1;
            if (r_v1) begin
                r_prod <= w_prod;
            end
        end
    end

    // Accumulator with sticky carry-out; cleared when the result is taken
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_acc <= '0;
            r_ovf <= 1'b0;
        end else if (w_out_hs) begin
            r_acc <= '0;
            r_ovf <= 1'b0;
        end else if (r_v2) begin
            r_acc <= w_sum[ACC_W-1:0];
            r_ovf <= r_ovf | w_sum[ACC_W];
        end
    end

    // Element counter, wraps after the last element of a vector
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (w_accept) begin
            r_cnt <= (r_cnt == c_LAST) ? '0 : r_cnt + 1'b1;
        end
    end

    // FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_ACCUM;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM next state and stream outputs. DRAIN ends on the edge where the
    // last product (v2 set, nothing left in stage 1) enters the accumulator.
    always_comb begin
        w_state_nxt = r_state;
        w_in_ready  = 1'b0;
        unique case (r_state)
            ST_ACCUM: begin
                w_in_ready = 1'b1;
                if (w_accept && (r_cnt == c_LAST)) begin
                    w_state_nxt = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (r_v2 && !r_v1) begin
                    w_state_nxt = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (bus.out_ready) begin
                    w_state_nxt = ST_ACCUM;
                end
            end
            default: begin
                w_state_nxt = ST_ACCUM;
            end
        endcase
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = (r_state == ST_HOLD);
    assign bus.out_sum   = r_acc;
    assign bus.out_ovf   = r_ovf;

endmodule : dot_product_accum
`default_nettype wire

// File: tb/tb_dot_product_accum.sv
`default_nettype none
// ============================================================================
// Module      : tb_dot_product_accum
// Description : Directed self-checking bench. Instance A uses VEC_LEN=4,
//               ACC_W=20; instance B uses VEC_LEN=2, ACC_W=16 for overflow.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dot_product_accum;

    logic clk;
    logic rst;
    int   checks = 0;
    int   errors = 0;
    int   n;

    dot_product_accum_if #(.ACC_W(20)) ifa ();
    dot_product_accum_if #(.ACC_W(16)) ifb ();

    dot_product_accum #(.VEC_LEN(4), .ACC_W(20), .CNT_W(8)) dut_a (
        .clk (clk),
        .rst (rst),
        .bus (ifa)
    );

    dot_product_accum #(.VEC_LEN(2), .ACC_W(16), .CNT_W(8)) dut_b (
        .clk (clk),
        .rst (rst),
        .bus (ifb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic idle(input int cycles);
        repeat (cycles) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_a(input logic [7:0] a, input logic [7:0] b);
        int guard = 0;
        while (!ifa.in_ready && guard < 50) begin
            @(posedge clk);
            #1;
            guard++;
        end
        if (guard >= 50) check("send_a_ready_timeout", ifa.in_ready, 1);
        ifa.in_valid = 1'b1;
        ifa.in_a     = a;
        ifa.in_b     = b;
        @(posedge clk);
        #1;
        ifa.in_valid = 1'b0;
        ifa.in_a     = 8'hAA;
        ifa.in_b     = 8'h55;
    endtask

    task automatic send_b(input logic [7:0] a, input logic [7:0] b);
        int guard = 0;
        while (!ifb.in_ready && guard < 50) begin
            @(posedge clk);
            #1;
            guard++;
        end
        if (guard >= 50) check("send_b_ready_timeout", ifb.in_ready, 1);
        ifb.in_valid = 1'b1;
        ifb.in_a     = a;
        ifb.in_b     = b;
        @(posedge clk);
        #1;
        ifb.in_valid = 1'b0;
        ifb.in_a     = 8'hAA;
        ifb.in_b     = 8'h55;
    endtask

    // Edges from the last accept until out_valid is seen (2 expected)
    task automatic wait_valid_a(output int cycles);
        cycles = 0;
        while (!ifa.out_valid && cycles < 20) begin
            @(posedge clk);
            #1;
            cycles++;
        end
    endtask

    task automatic wait_valid_b(output int cycles);
        cycles = 0;
        while (!ifb.out_valid && cycles < 20) begin
            @(posedge clk);
            #1;
            cycles++;
        end
    endtask

    initial begin
        rst = 1'b1;
        ifa.in_valid = 1'b0; ifa.in_a = '0; ifa.in_b = '0; ifa.out_ready = 1'b0;
        ifb.in_valid = 1'b0; ifb.in_a = '0; ifb.in_b = '0; ifb.out_ready = 1'b0;
        idle(2);

        // Reset state
        check("rst_in_ready",  ifa.in_ready,  1);
        check("rst_out_valid", ifa.out_valid, 0);
        check("rst_out_sum",   ifa.out_sum,   0);
        check("rst_out_ovf",   ifa.out_ovf,   0);
        check("rst_b_in_ready", ifb.in_ready, 1);
        rst = 1'b0;
        idle(1);

        // Basic vector: 15 + 100 + 65025 + 0 = 65140
        ifa.out_ready = 1'b1;
        send_a(8'd3, 8'd5);
        send_a(8'd10, 8'd10);
        send_a(8'd255, 8'd255);
        send_a(8'd0, 8'd7);
        check("basic_drain_in_ready", ifa.in_ready, 0);
        wait_valid_a(n);
        check("basic_latency", n, 2);
        check("basic_sum", ifa.out_sum, 65140);
        check("basic_ovf", ifa.out_ovf, 0);
        idle(1);
        check("basic_pulse_end", ifa.out_valid, 0);
        check("basic_in_ready_back", ifa.in_ready, 1);

        // Backpressure: 77 + 221 + 437 + 899 = 1634
        ifa.out_ready = 1'b0;
        send_a(8'd7, 8'd11);
        send_a(8'd13, 8'd17);
        send_a(8'd19, 8'd23);
        send_a(8'd29, 8'd31);
        check("bp_drain_in_ready", ifa.in_ready, 0);
        wait_valid_a(n);
        check("bp_latency", n, 2);
        for (int i = 0; i < 6; i++) begin
            check("bp_hold_valid", ifa.out_valid, 1);
            check("bp_hold_sum", ifa.out_sum, 1634);
            check("bp_hold_in_ready", ifa.in_ready, 0);
            idle(1);
        end
        ifa.out_ready = 1'b1;
        idle(1);
        check("bp_release_valid", ifa.out_valid, 0);
        check("bp_release_in_ready", ifa.in_ready, 1);

        // Bubbles between elements: 6 + 20 + 42 + 72 = 140
        send_a(8'd2, 8'd3);
        idle(1);
        send_a(8'd4, 8'd5);
        idle(1);
        send_a(8'd6, 8'd7);
        idle(1);
        send_a(8'd8, 8'd9);
        wait_valid_a(n);
        check("bubble_latency", n, 2);
        check("bubble_sum", ifa.out_sum, 140);
        idle(1);

        // Reset after two of four elements; aborted vector must vanish
        send_a(8'd50, 8'd50);
        send_a(8'd60, 8'd60);
        rst = 1'b1;
        #1;
        check("rst_mid_in_ready", ifa.in_ready, 1);
        check("rst_mid_out_valid", ifa.out_valid, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        send_a(8'd1, 8'd1);
        send_a(8'd1, 8'd1);
        send_a(8'd1, 8'd1);
        send_a(8'd1, 8'd1);
        wait_valid_a(n);
        check("rst_mid_latency", n, 2);
        check("rst_mid_sum", ifa.out_sum, 4);
        idle(1);

        // Reset while holding a result: 4 * 4 = 16
        ifa.out_ready = 1'b0;
        send_a(8'd2, 8'd2);
        send_a(8'd2, 8'd2);
        send_a(8'd2, 8'd2);
        send_a(8'd2, 8'd2);
        wait_valid_a(n);
        check("rst_hold_sum", ifa.out_sum, 16);
        rst = 1'b1;
        #1;
        check("rst_hold_valid_drop", ifa.out_valid, 0);
        check("rst_hold_sum_clear", ifa.out_sum, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        ifa.out_ready = 1'b1;
        check("rst_hold_in_ready", ifa.in_ready, 1);

        // Back-to-back vectors: 8 then 36
        for (int i = 0; i < 4; i++) send_a(8'd1, 8'd2);
        wait_valid_a(n);
        check("b2b_v1_latency", n, 2);
        check("b2b_v1_sum", ifa.out_sum, 8);
        idle(1);
        check("b2b_gap_in_ready", ifa.in_ready, 1);
        for (int i = 0; i < 4; i++) send_a(8'd3, 8'd3);
        wait_valid_a(n);
        check("b2b_v2_latency", n, 2);
        check("b2b_v2_sum", ifa.out_sum, 36);
        idle(1);

        // Overflow on the 16-bit instance: 130050 mod 65536 = 64514
        ifb.out_ready = 1'b1;
        send_b(8'd255, 8'd255);
        send_b(8'd255, 8'd255);
        wait_valid_b(n);
        check("ovf_latency", n, 2);
        check("ovf_sum", ifb.out_sum, 64514);
        check("ovf_flag", ifb.out_ovf, 1);
        send_b(8'd1, 8'd1);
        send_b(8'd2, 8'd2);
        wait_valid_b(n);
        check("ovf_next_sum", ifb.out_sum, 5);
        check("ovf_next_flag", ifb.out_ovf, 0);
        idle(2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_dot_product_accum
`default_nettype wire

// File: doc/dot_product_accum.md
Name: dot_product_accum

Overview:
- Sequential multiply-accumulate stage built around the team's combinational 8x8 unsigned Wallace multiplier.
- Registers operand pairs arriving on a valid/ready stream and feeds them to the multiplier.
- Registers each 16-bit product and accumulates VEC_LEN products into one dot-product result.
- Presents each result on a valid/ready output stream. Sits between the operand-fetch logic and the result writeback.

Parameters:
- VEC_LEN, 4, products per dot product; legal range 1..256.
- ACC_W, 20, accumulator and result width in bits; legal range 16..32.
- CNT_W, 8, element counter width; must satisfy 2^CNT_W >= VEC_LEN.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  operand pair valid.
- in_ready  output  1  block accepts an operand pair this cycle.
- in_a  input  8  unsigned operand A.
- in_b  input  8  unsigned operand B.
- out_valid  output  1  dot-product result valid.
- out_ready  input  1  consumer accepts the result.
- out_sum  output  ACC_W  sum of VEC_LEN products, modulo 2^ACC_W.
- out_ovf  output  1  sticky flag: the accumulation carried out of ACC_W bits during this vector.

Behaviour:
- Reset, asynchronous and immediate:
  - state=ACCUM; element count=0; accumulator=0; ovf=0.
  - Stage-1 and stage-2 valid bits=0; operand and product registers=0.
  - Outputs: in_ready=1, out_valid=0, out_sum=0, out_ovf=0.
  - Reset mid-vector or mid-hold discards all in-flight data; no partial result is ever emitted.
- Input accept: in_valid && in_ready at a rising edge.
- Pipeline:
  - Stage 1 registers in_a/in_b and sets v1.
  - The multiplier sub-module computes the product combinationally from the stage-1 registers.
  - Stage 2 registers the product and sets v2.
  - On an edge with v2=1, accumulator += product (ACC_W+1-bit add). A carry-out sets ovf.
  - Bubbles (in_valid=0) propagate as v1/v2=0; the accumulator is unchanged on v2=0.
- Latency: last element accepted at edge E. The final sum is registered at edge E+2, and out_valid=1 in the cycle after edge E+2.
- Throughput: one pair per cycle while in ACCUM.
- FSM:
  - ACCUM: in_ready=1. On accept, the count increments. When the accepted element is number VEC_LEN (count==VEC_LEN-1), count resets to 0 and the FSM goes to DRAIN.
  - DRAIN: in_ready=0. The FSM waits until the last element has been accumulated (two edges). It then goes to HOLD with out_valid=1, out_sum=accumulator, out_ovf=ovf.
  - HOLD: in_ready=0. out_sum and out_ovf stay stable while out_ready=0. On out_valid && out_ready: accumulator=0, ovf=0, out_valid=0, go to ACCUM. in_ready returns to 1 in the following cycle; there is no same-cycle bypass.
- VEC_LEN=1: every accept goes directly to DRAIN.
- Products are unsigned and zero-extended to ACC_W; the sum wraps modulo 2^ACC_W.
- The ovf flag is cleared only on result handshake or reset.
- in_a/in_b are ignored when no accept occurs.
- out_ready is ignored outside HOLD.

Decomposition:
- Shared package holds:
  - Operand width 8 and product width 16.
  - FSM state encoding (ACCUM, DRAIN, HOLD).
  - Default VEC_LEN and ACC_W.
- One sub-module: the existing combinational 8x8 multiplier, parallel_unsigned_mult, instantiated between the stage-1 and stage-2 registers. All other logic stays in this module.

Test Plan:
- Basic vector: VEC_LEN=4, ACC_W=20, pairs (3,5),(10,10),(255,255),(0,7) back-to-back, out_ready=1. Required: one out_valid pulse with out_sum=65140, out_ovf=0, 3 cycles after the last accept.
- Overflow: ACC_W=16, VEC_LEN=2, pairs (255,255),(255,255). Required: out_sum=64514 (130050 mod 65536), out_ovf=1. The next vector (1,1),(2,2) gives out_sum=5, out_ovf=0.
- Backpressure: complete a vector with out_ready=0 for 6 cycles. Required: out_valid held and out_sum constant; in_ready=0 throughout DRAIN and HOLD; in_ready=1 one cycle after the handshake.
- Bubbles: VEC_LEN=4 with pairs (2,3),(4,5),(6,7),(8,9) and in_valid alternating 1/0. Required: out_sum=6+20+42+72=140, and no extra or missing accumulation.
- Reset mid-operation:
  - Assert rst after 2 of 4 elements are accepted; then send (1,1)x4. Required: out_sum=4, with no result from the aborted vector.
  - Assert rst during HOLD. Required: out_valid drops immediately.
- Back-to-back vectors: two vectors of (1,2)x4 then (3,3)x4 with out_ready=1. Required: results 8 then 36, in order, with in_ready gaps only during DRAIN, HOLD and the following cycle.
